message_scroll_controller: RTL and testbench

//   Sequencer that scrolls a MSG_LEN-character message across the four 7-seg digits.

---
 rtl/message_scroll_controller_pkg.sv | 15 +
 rtl/message_scroll_controller_step_gen.sv | 49 ++++
 rtl/message_scroll_controller.sv | 133 +++++++++++++
 tb/tb_message_scroll_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/message_scroll_controller_pkg.sv
// Shared definitions for the message scroll sequencer.
// FSM states, fetch length and the reset blank character.
package message_scroll_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        COMMIT
    } state_t;

    localparam int         FETCH_CYCLES  = 4;
    localparam logic [3:0] BLANK_DEFAULT = 4'hF;

endpackage

// File: rtl/message_scroll_controller_step_gen.sv
// Step request source: button edge, auto-scroll tick and sticky pending flag.
// step_go stays high until the sequencer acknowledges it.
module message_scroll_controller_step_gen
    import message_scroll_controller_pkg::*;
#(
    parameter int TICK_CYCLES = 1562500
) (
    input  logic clk,
    input  logic n_reset,
    input  logic button,
    input  logic auto_en,
    input  logic ack,
    output logic step_go
);

    localparam int CW = $clog2(TICK_CYCLES + 1);

    logic          btn_d;
    logic [CW-1:0] tick_cnt;
    logic          pending;
    logic          tick;
    logic          step;

    assign tick    = auto_en && (tick_cnt == CW'(TICK_CYCLES - 1));
    assign step    = (button & ~btn_d) | tick;
    assign step_go = step | pending;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            btn_d    <= 1'b0;
            tick_cnt <= '0;
            pending  <= 1'b0;
        end else begin
            btn_d <= button;
            if (!auto_en || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CW'(1);
            end
            // A step arriving with the ack merges into the served one
            if (ack) begin
                pending <= 1'b0;
            end else begin
                pending <= pending | step;
            end
        end
    end

endmodule

// File: rtl/message_scroll_controller.sv
// Scrolls a message across four 7-seg digits, fetching four chars per step
// from a 1-cycle-latency memory and committing them all at once.
module message_scroll_controller
    import message_scroll_controller_pkg::*;
#(
    parameter int         MSG_LEN     = 16,
    parameter int         ADDR_W      = 4,
    parameter int         TICK_CYCLES = 1562500,
    parameter logic [3:0] BLANK_CHAR  = BLANK_DEFAULT
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              button,
    input  logic              auto_en,
    input  logic              dir,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [3:0]        rd_data,
    output logic [3:0]        an3char,
    output logic [3:0]        an2char,
    output logic [3:0]        an1char,
    output logic [3:0]        an0char,
    output logic              upd,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MSG_LEN - 1);

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST) ? '0 : a + ADDR_W'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] wrap_dec(input logic [ADDR_W-1:0] a);
        return (a == '0) ? LAST : a - ADDR_W'(1);
    endfunction

    state_t            state;
    state_t            state_nxt;
    logic              init;
    logic              ack;
    logic              step_go;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] off_nxt;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        k;
    logic              cap_vld;
    logic [1:0]        cap_idx;
    logic [3:0]        shadow [4];

    message_scroll_controller_step_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_step (
        .clk    (clk),
        .n_reset(n_reset),
        .button (button),
        .auto_en(auto_en),
        .ack    (ack),
        .step_go(step_go)
    );

    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        off_nxt   = offset;
        unique case (state)
            IDLE: begin
                // The first load after reset keeps offset and leaves steps pending
                if (init) begin
                    state_nxt = FETCH;
                end else if (step_go) begin
                    state_nxt = FETCH;
                    ack       = 1'b1;
                    off_nxt   = dir ? wrap_dec(offset) : wrap_inc(offset);
                end
            end
            FETCH: begin
                if (k == 2'(FETCH_CYCLES - 1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state   <= IDLE;
            init    <= 1'b1;
            offset  <= '0;
            addr    <= '0;
            k       <= '0;
            cap_vld <= 1'b0;
            cap_idx <= '0;
            an3char <= BLANK_CHAR;
            an2char <= BLANK_CHAR;
            an1char <= BLANK_CHAR;
            an0char <= BLANK_CHAR;
        end else begin
            state   <= state_nxt;
            init    <= 1'b0;
            cap_vld <= (state == FETCH);
            cap_idx <= k;
            if (state == IDLE && state_nxt == FETCH) begin
                offset <= off_nxt;
                addr   <= off_nxt;
                k      <= '0;
            end else if (state == FETCH) begin
                addr <= wrap_inc(addr);
                k    <= k + 2'd1;
            end
            if (state == COMMIT) begin
                an3char <= shadow[0];
                an2char <= shadow[1];
                an1char <= shadow[2];
                an0char <= shadow[3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_vld) begin
            shadow[cap_idx] <= rd_data;
        end
    end

    assign rd_en   = (state == FETCH);
    assign rd_addr = rd_en ? addr : '0;
    assign upd     = (state == COMMIT);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_message_scroll_controller.sv
// Bench for message_scroll_controller: per-cycle model compare
// plus directed scenarios with literal expectations.
module tb_message_scroll_controller;

    localparam int L = 16;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       button;
    logic       auto_en;
    logic       dir;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [3:0] rd_data;
    logic [3:0] an3char;
    logic [3:0] an2char;
    logic [3:0] an1char;
    logic [3:0] an0char;
    logic       upd;
    logic       busy;

    int errors = 0;
    int checks = 0;

    message_scroll_controller #(
        .MSG_LEN    (L),
        .ADDR_W     (4),
        .TICK_CYCLES(T),
        .BLANK_CHAR (4'hF)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .button (button),
        .auto_en(auto_en),
        .dir    (dir),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .an3char(an3char),
        .an2char(an2char),
        .an1char(an1char),
        .an0char(an0char),
        .upd    (upd),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Message memory: char i holds value i, one cycle of read latency
    always @(posedge clk) rd_data <= rd_addr;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Model: phase 0 idle, 1..4 fetch index 0..3, 5 drain, 6 commit
    int         m_p;
    int         m_off;
    int         m_tcnt;
    bit         m_init;
    bit         m_pend;
    bit         m_btnd;
    bit         m_valid = 1'b0;
    bit         m_tick;
    bit         m_step;
    logic [3:0] m_disp [4];

    always @(posedge clk) begin
        if (!n_reset) begin
            m_p     = 0;
            m_init  = 1'b1;
            m_off   = 0;
            m_tcnt  = 0;
            m_pend  = 1'b0;
            m_btnd  = 1'b0;
            m_valid = 1'b1;
            for (int i = 0; i < 4; i++) m_disp[i] = 4'hF;
        end else if (m_valid) begin
            m_tick = auto_en && (m_tcnt == T - 1);
            m_step = (button && !m_btnd) || m_tick;
            m_tcnt = (!auto_en || m_tick) ? 0 : m_tcnt + 1;
            m_btnd = button;
            if (m_p == 0) begin
                if (m_init) begin
                    m_init = 1'b0;
                    m_pend = m_pend || m_step;
                    m_p    = 1;
                end else if (m_step || m_pend) begin
                    m_off  = dir ? (m_off + L - 1) % L : (m_off + 1) % L;
                    m_pend = 1'b0;
                    m_p    = 1;
                end
            end else begin
                if (m_step) m_pend = 1'b1;
                if (m_p == 6) begin
                    for (int i = 0; i < 4; i++) m_disp[i] = 4'((m_off + i) % L);
                    m_p = 0;
                end else begin
                    m_p++;
                end
            end
        end
    end

    logic [22:0] m_exp;
    always @(negedge clk) begin
        if (m_valid) begin
            m_exp = {(m_p >= 1 && m_p <= 4),
                     (m_p >= 1 && m_p <= 4) ? 4'((m_off + m_p - 1) % L) : 4'h0,
                     (m_p == 6), (m_p != 0),
                     m_disp[0], m_disp[1], m_disp[2], m_disp[3]};
            chk("cycle", {9'd0, rd_en, rd_addr, upd, busy,
                          an3char, an2char, an1char, an0char}, {9'd0, m_exp});
        end
    end

    function automatic logic [15:0] chars();
        return {an3char, an2char, an1char, an0char};
    endfunction

    task automatic run_upd(input int maxc, output int ncyc, output int nrd);
        bit seen;
        seen = 1'b0;
        ncyc = 0;
        nrd  = 0;
        while (!seen && ncyc < maxc) begin
            @(negedge clk);
            ncyc++;
            if (rd_en) nrd++;
            seen = upd;
        end
        chk("upd_seen", 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    task automatic press();
        @(posedge clk);
        #2 button = 1'b1;
        @(posedge clk);
        #2 button = 1'b0;
    endtask

    task automatic count_upd(input int ncyc, output int n);
        n = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (upd) n++;
        end
    endtask

    task automatic step_and_check(input bit d, input logic [15:0] exp, input string nm);
        int n;
        int r;
        dir = d;
        press();
        run_upd(8, n, r);
        chk(nm, 32'(chars()), 32'(exp));
    endtask

    initial begin
        int n;
        int r;
        int p1;
        int p2;
        n_reset = 1'b0;
        button  = 1'b0;
        auto_en = 1'b0;
        dir     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_chars", 32'(chars()), 32'h0000_FFFF);
        chk("reset_rd_en", 32'(rd_en), 32'd0);

        @(posedge clk);
        #2 n_reset = 1'b1;
        run_upd(20, n, r);
        chk("init_chars", 32'(chars()), 32'h0123);
        chk("init_rd_cycles", 32'(r), 32'd4);

        dir = 1'b0;
        press();
        run_upd(8, n, r);
        chk("press_chars", 32'(chars()), 32'h1234);
        chk("press_latency", 32'(n <= 7), 32'd1);

        step_and_check(1'b1, 16'h0123, "back_to_0");
        step_and_check(1'b1, 16'hF012, "wrap_back");
        step_and_check(1'b1, 16'hEF01, "off_14");
        step_and_check(1'b0, 16'hF012, "off_15");
        step_and_check(1'b0, 16'h0123, "wrap_fwd");

        press();
        press();
        press();
        count_upd(30, n);
        chk("busy_upd_count", 32'(n), 32'd2);
        chk("busy_chars", 32'(chars()), 32'h2345);

        @(posedge clk);
        #2 auto_en = 1'b1;
        p1 = -1;
        p2 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (upd) begin
                if (p1 < 0) p1 = i;
                else if (p2 < 0) p2 = i;
            end
        end
        chk("auto_period", 32'(p2 - p1), 32'd8);

        n = 0;
        while (!upd && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("auto_upd_seen", 32'(upd), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #2 button = 1'b1;
        @(posedge clk);
        #2 button = 1'b0;
        auto_en = 1'b0;
        count_upd(20, n);
        chk("coincide_upd", 32'(n), 32'd1);

        press();
        n_reset = 1'b0;
        @(negedge clk);
        chk("in_fetch", 32'(rd_en), 32'd1);
        @(negedge clk);
        chk("midreset_chars", 32'(chars()), 32'h0000_FFFF);
        chk("midreset_rd_upd", {30'd0, rd_en, upd}, 32'd0);
        @(posedge clk);
        #2 n_reset = 1'b1;
        run_upd(20, n, r);
        chk("reload_chars", 32'(chars()), 32'h0123);
        chk("reload_rd_cycles", 32'(r), 32'd4);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
